mem_stage: RTL and testbench

- Memory-access pipeline stage; the initiator side of the data-memory interface.
- Takes the EX/MEM latch fields (ALU result as address, rs2 as store data, MemRead/MemWrite) and drives a request/acknowledge data memory.
- Stalls the pipeline until the memory responds or the access times out, then presents a registered MEM/WB result to write-back.
- Sits between the EX stage (ALU) and the register-file write port.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_timeout_ctr.sv | 31 +++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-access pipeline stage: widths,
// FSM state encoding, default timeout and the MEM/WB result bundle.
package cpu_pkg;

    localparam int DW      = 32;
    localparam int RW      = 6;
    localparam int TIMEOUT = 16;

    // Wide enough for any timeout up to 255 cycles
    localparam int CTR_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } memwb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge data-memory bus. The pipeline stage is the master
// (issues requests), the data memory is the slave (acknowledges them).
interface mem_stage_if #(
    parameter int DW = cpu_pkg::DW
);

    logic          req;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts memory wait cycles and flags the last cycle before an access
// must be abandoned.
module mem_timeout_ctr #(
    parameter int TIMEOUT = cpu_pkg::TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = cpu_pkg::CTR_W;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Wait counter: clear has priority so a fresh access always starts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Issues loads and stores on the data-memory
// bus, stalls upstream while waiting, and hands a registered result to
// write-back. Accesses that never get acknowledged are aborted with err.
module mem_stage #(
    parameter int DW      = cpu_pkg::DW,
    parameter int RW      = cpu_pkg::RW,
    parameter int TIMEOUT = cpu_pkg::TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ex_valid,
    input  logic           ex_mem_read,
    input  logic           ex_mem_write,
    input  logic [DW-1:0]  ex_alu_result,
    input  logic [DW-1:0]  ex_rs2,
    input  logic [RW-1:0]  ex_rd,
    input  logic           ex_reg_write,
    mem_stage_if.master    dm,
    output logic           stall,
    output logic           wb_valid,
    output logic           wb_reg_write,
    output logic [RW-1:0]  wb_rd,
    output logic [DW-1:0]  wb_data,
    output logic           err
);

    import cpu_pkg::state_t;
    import cpu_pkg::memwb_t;
    import cpu_pkg::IDLE;
    import cpu_pkg::BUSY;

    state_t        state, state_n;
    logic          req_q, req_n;
    logic          we_q, we_n;
    logic [DW-1:0] addr_q, addr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic [RW-1:0] lat_rd_q, lat_rd_n;
    logic          lat_rw_q, lat_rw_n;
    memwb_t        wb_q, wb_n;
    logic          err_q, err_n;
    logic          ctr_clear, ctr_en, ctr_term;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear    (ctr_clear),
        .enable   (ctr_en),
        .terminal (ctr_term)
    );

    // State and every output are registered; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_rd_q <= '0;
            lat_rw_q <= 1'b0;
            wb_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            req_q    <= req_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            lat_rd_q <= lat_rd_n;
            lat_rw_q <= lat_rw_n;
            wb_q     <= wb_n;
            err_q    <= err_n;
        end
    end

    // Next-state and next-output decisions; bus fields hold unless changed
    always_comb begin
        state_n      = state;
        req_n        = req_q;
        we_n         = we_q;
        addr_n       = addr_q;
        wdata_n      = wdata_q;
        lat_rd_n     = lat_rd_q;
        lat_rw_n     = lat_rw_q;
        wb_n         = wb_q;
        wb_n.valid     = 1'b0;
        wb_n.reg_write = 1'b0;
        err_n        = 1'b0;
        ctr_clear    = 1'b0;
        ctr_en       = 1'b0;

        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_mem_read && ex_mem_write) begin
                        err_n          = 1'b1;
                        wb_n.valid     = 1'b1;
                        wb_n.reg_write = 1'b0;
                        wb_n.rd        = ex_rd;
                        wb_n.data      = '0;
                    end else if (ex_mem_read || ex_mem_write) begin
                        state_n   = BUSY;
                        req_n     = 1'b1;
                        we_n      = ex_mem_write;
                        addr_n    = ex_alu_result;
                        wdata_n   = ex_rs2;
                        lat_rd_n  = ex_rd;
                        lat_rw_n  = ex_reg_write;
                        ctr_clear = 1'b1;
                    end else begin
                        wb_n.valid     = 1'b1;
                        wb_n.reg_write = ex_reg_write;
                        wb_n.rd        = ex_rd;
                        wb_n.data      = ex_alu_result;
                    end
                end
            end
            BUSY: begin
                if (dm.ack) begin
                    state_n        = IDLE;
                    req_n          = 1'b0;
                    ctr_clear      = 1'b1;
                    wb_n.valid     = 1'b1;
                    wb_n.rd        = lat_rd_q;
                    wb_n.reg_write = we_q ? 1'b0 : lat_rw_q;
                    wb_n.data      = we_q ? '0 : dm.rdata;
                end else if (ctr_term) begin
                    state_n        = IDLE;
                    req_n          = 1'b0;
                    ctr_clear      = 1'b1;
                    err_n          = 1'b1;
                    wb_n.valid     = 1'b1;
                    wb_n.reg_write = 1'b0;
                    wb_n.rd        = lat_rd_q;
                    wb_n.data      = '0;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    assign dm.req   = req_q;
    assign dm.we    = we_q;
    assign dm.addr  = addr_q;
    assign dm.wdata = wdata_q;

    assign stall        = (state == BUSY);
    assign wb_valid     = wb_q.valid;
    assign wb_reg_write = wb_q.reg_write;
    assign wb_rd        = wb_q.rd;
    assign wb_data      = wb_q.data;
    assign err          = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// loads, stores, pass-throughs and illegal ops against a simple outcome model.
module tb_mem_stage;

    localparam int TMO       = 16;
    localparam int K_PASS    = 0;
    localparam int K_LOAD    = 1;
    localparam int K_STORE   = 2;
    localparam int K_ILLEGAL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2;
    logic [5:0]  ex_rd;
    logic        ex_reg_write;
    logic        stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [5:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    int errors = 0;
    int checks = 0;

    mem_stage_if dm_bus ();

    mem_stage #(
        .DW      (32),
        .RW      (6),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_alu_result (ex_alu_result),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .dm            (dm_bus.master),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Hard stop in case something waits forever
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One instruction end to end; ackAt = request cycle carrying dm_ack (0 = never)
    task automatic applyStimulus(input int kind, input logic [31:0] alu, input logic [31:0] rs2,
                                 input logic [5:0] rd, input logic rw, input int ackAt,
                                 input logic [31:0] rdata);
        bit isMem, isStore, timedOut, expErr, expRw, holdOk;
        int expReq, reqCycles;

        isMem    = (kind == K_LOAD) || (kind == K_STORE);
        isStore  = (kind == K_STORE);
        timedOut = isMem && !(ackAt >= 1 && ackAt <= TMO);
        expReq   = !isMem ? 0 : (timedOut ? TMO : ackAt);
        expErr   = (kind == K_ILLEGAL) || timedOut;
        expRw    = ((kind == K_PASS) || (kind == K_LOAD && !timedOut)) ? rw : 1'b0;

        ex_valid      = 1'b1;
        ex_mem_read   = (kind == K_LOAD) || (kind == K_ILLEGAL);
        ex_mem_write  = (kind == K_STORE) || (kind == K_ILLEGAL);
        ex_alu_result = alu;
        ex_rs2        = rs2;
        ex_rd         = rd;
        ex_reg_write  = rw;
        @(negedge clk);

        // While frozen, EX carries junk that must be ignored
        if (isMem) begin
            ex_valid      = 1'b1;
            ex_mem_read   = 1'($urandom);
            ex_mem_write  = 1'($urandom);
            ex_alu_result = $urandom;
            ex_rs2        = $urandom;
            ex_rd         = 6'($urandom);
        end else begin
            ex_valid = 1'b0;
        end

        reqCycles = 0;
        holdOk    = 1'b1;
        while (dm_bus.req === 1'b1 && reqCycles < 4 * TMO) begin
            reqCycles++;
            if (stall !== 1'b1 || dm_bus.we !== isStore || dm_bus.addr !== alu ||
                (isStore && dm_bus.wdata !== rs2))
                holdOk = 1'b0;
            dm_bus.ack   = (reqCycles == ackAt);
            dm_bus.rdata = (reqCycles == ackAt) ? rdata : $urandom;
            if (reqCycles == 1) ex_valid = (kind == K_PASS);
            @(negedge clk);
            dm_bus.ack = 1'b0;
            ex_valid   = 1'b0;
        end
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;

        checkWord("req_cycles", reqCycles, expReq);
        if (isMem) checkBit("bus_hold", holdOk, 1'b1);
        checkBit("req_done", dm_bus.req, 1'b0);
        checkBit("stall_done", stall, 1'b0);
        checkBit("wb_valid", wb_valid, 1'b1);
        checkBit("err", err, expErr);
        checkBit("wb_reg_write", wb_reg_write, expRw);
        if (kind == K_PASS) checkWord("wb_data_pass", wb_data, alu);
        if (kind == K_LOAD && !timedOut) checkWord("wb_data_load", wb_data, rdata);
        if (kind == K_STORE && !timedOut) checkWord("wb_data_store", wb_data, 32'h0);
        if (kind == K_PASS || (isMem && !timedOut)) checkWord("wb_rd", 32'(wb_rd), 32'(rd));

        @(negedge clk);
        checkBit("wb_valid_pulse", wb_valid, 1'b0);
        checkBit("err_pulse", err, 1'b0);
    endtask

    // Reset-state snapshot of every output
    task automatic checkOutput();
        checkBit("rst_req", dm_bus.req, 1'b0);
        checkBit("rst_we", dm_bus.we, 1'b0);
        checkWord("rst_addr", dm_bus.addr, 32'h0);
        checkWord("rst_wdata", dm_bus.wdata, 32'h0);
        checkBit("rst_stall", stall, 1'b0);
        checkBit("rst_wb_valid", wb_valid, 1'b0);
        checkBit("rst_wb_reg_write", wb_reg_write, 1'b0);
        checkWord("rst_wb_rd", 32'(wb_rd), 32'h0);
        checkWord("rst_wb_data", wb_data, 32'h0);
        checkBit("rst_err", err, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        ex_valid      = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_alu_result = '0;
        ex_rs2        = '0;
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        dm_bus.ack    = 1'b0;
        dm_bus.rdata  = '0;

        @(negedge clk);
        @(negedge clk);
        checkOutput();
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed scenarios");
        applyStimulus(K_PASS, 32'd28, $urandom, 6'd5, 1'b1, 0, 32'h0);
        applyStimulus(K_LOAD, 32'd18, $urandom, 6'd5, 1'b1, 1, 32'hDEADBEEF);
        applyStimulus(K_STORE, 32'd7, 32'h55, 6'd9, 1'b1, 3, $urandom);
        applyStimulus(K_LOAD, $urandom, $urandom, 6'd12, 1'b1, 0, $urandom);
        applyStimulus(K_LOAD, $urandom, $urandom, 6'd13, 1'b1, TMO, 32'h1234_5678);
        applyStimulus(K_ILLEGAL, $urandom, $urandom, 6'd3, 1'b1, 0, 32'h0);

        // A stray acknowledge while idle must not start or finish anything
        dm_bus.ack = 1'b1;
        @(negedge clk);
        dm_bus.ack = 1'b0;
        checkBit("idle_ack_req", dm_bus.req, 1'b0);
        checkBit("idle_ack_wb", wb_valid, 1'b0);

        // Reset two cycles into a pending load
        $display("[TB] reset during access");
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_mem_write  = 1'b0;
        ex_alu_result = $urandom;
        ex_rd         = 6'd20;
        ex_reg_write  = 1'b1;
        @(negedge clk);
        ex_valid    = 1'b0;
        ex_mem_read = 1'b0;
        checkBit("busy_req", dm_bus.req, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkBit("async_req_drop", dm_bus.req, 1'b0);
        checkBit("async_stall_drop", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        checkBit("rst_abandon_wb", wb_valid, 1'b0);
        checkBit("rst_abandon_err", err, 1'b0);
        @(negedge clk);
        checkBit("rst_after_wb", wb_valid, 1'b0);
        applyStimulus(K_PASS, $urandom, $urandom, 6'd31, 1'b1, 0, 32'h0);

        $display("[TB] random operations");
        for (int i = 0; i < 30; i++) begin
            int kind;
            int pick;
            pick = $urandom_range(0, 9);
            kind = (pick < 3) ? K_PASS : (pick < 6) ? K_LOAD : (pick < 9) ? K_STORE : K_ILLEGAL;
            applyStimulus(kind, $urandom, $urandom, 6'($urandom), 1'($urandom),
                          $urandom_range(0, TMO + 2), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
